spi_screen: RTL and testbench

// - Write-only SPI master that drives the display controller of the Hack CPU system.
// - A one-cycle start strobe sends one of three frames: an 8-bit command, 8-bit data, or 16-bit data.
// - The top level memory-maps three start strobes; a CPU read of any of those addresses returns `ready`
//   (0xFFFF when high, 0x0000 when low). Software polls `ready` before each write.

---
 rtl/spi_screen_pkg.sv | 47 ++++
 rtl/spi_screen_if.sv | 22 ++
 rtl/spi_screen_tick.sv | 28 ++
 rtl/spi_screen.sv | 101 ++++++++++
 tb/tb_spi_screen.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_screen_pkg.sv
// Shared types, constants and payload helpers for the spi_screen display link.
// Optional build macro: SPI_LSB_FIRST_EN (defined = shift LSB first, payload right-aligned).
package spi_screen_pkg;

  typedef enum logic [1:0] {FR_CMD, FR_D8, FR_D16} frame_t;
  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  localparam int BITS8  = 8;
  localparam int BITS16 = 16;

  // Place the payload in the shift register so the first bit to send sits at the output end.
  function automatic logic [15:0] load_word(frame_t fr, logic [15:0] d);
`ifdef SPI_LSB_FIRST_EN
    return (fr == FR_D16) ? d : {8'h00, d[7:0]};
`else
    return (fr == FR_D16) ? d : {d[7:0], 8'h00};
`endif
  endfunction

  // Bit presented on mosi right after loading.
  function automatic logic first_bit(logic [15:0] w);
`ifdef SPI_LSB_FIRST_EN
    return w[0];
`else
    return w[15];
`endif
  endfunction

  // Shift register after one bit has been sent.
  function automatic logic [15:0] shift_word(logic [15:0] w);
`ifdef SPI_LSB_FIRST_EN
    return {1'b0, w[15:1]};
`else
    return {w[14:0], 1'b0};
`endif
  endfunction

  // Bit that becomes visible on mosi once the register shifts.
  function automatic logic next_bit(logic [15:0] w);
`ifdef SPI_LSB_FIRST_EN
    return w[1];
`else
    return w[14];
`endif
  endfunction

endpackage

// File: rtl/spi_screen_if.sv
// CPU-side strobes/payload/ready and the SPI pins of the display link.
interface spi_screen_if;
  logic        startC;
  logic        startD8;
  logic        startD16;
  logic [15:0] data;
  logic        spi_mosi;
  logic        spi_sck;
  logic        spi_cdn;
  logic        spi_cen;
  logic        ready;

  modport master (
    output startC, startD8, startD16, data,
    input  spi_mosi, spi_sck, spi_cdn, spi_cen, ready
  );

  modport slave (
    input  startC, startD8, startD16, data,
    output spi_mosi, spi_sck, spi_cdn, spi_cen, ready
  );
endinterface

// File: rtl/spi_screen_tick.sv
// Baud divider: one-cycle tick every BAUD clocks while enabled; restarts on clr.
module spi_screen_tick #(
  parameter int BAUD = 5
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(BAUD + 1);
  localparam logic [CW-1:0] LAST = CW'(BAUD - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count clocks within a half sck period, wrapping on each tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr || !en || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/spi_screen.sv
// Write-only SPI master for the display: 8-bit command, 8-bit data or 16-bit data frames.
// Optional build macro: SPI_LSB_FIRST_EN (reverses shift direction, timing unchanged).
module spi_screen
  import spi_screen_pkg::*;
#(
  parameter int BAUD = 5
) (
  input logic         clk,
  input logic         rstn,
  spi_screen_if.slave bus
);
  state_t      state, state_next;
  frame_t      frame;
  logic        start_any, accept, finish, tick, shifting;
  logic [15:0] sreg, load_w;
  logic [4:0]  bits_left;
  logic        sck_q, cen_q, cdn_q, mosi_q, ready_q;

  assign start_any = bus.startC | bus.startD8 | bus.startD16;
  assign load_w    = load_word(frame, bus.data);
  assign shifting  = (state == S_SHIFT);

  spi_screen_tick #(.BAUD(BAUD)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (accept),
    .en   (shifting),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  // Frame selection by priority, accept in idle, finish on the falling tick of the last bit.
  always_comb begin
    state_next = state;
    frame      = FR_D16;
    accept     = 1'b0;
    finish     = 1'b0;
    if (bus.startC)       frame = FR_CMD;
    else if (bus.startD8) frame = FR_D8;
    case (state)
      S_IDLE: begin
        if (start_any) begin
          accept     = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick && sck_q && (bits_left == 5'd1)) begin
          finish     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Shift register, bit counter and registered SPI outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sreg      <= '0;
      bits_left <= '0;
      sck_q     <= 1'b0;
      cen_q     <= 1'b1;
      cdn_q     <= 1'b1;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else if (accept) begin
      sreg      <= load_w;
      bits_left <= (frame == FR_D16) ? 5'(BITS16) : 5'(BITS8);
      cdn_q     <= (frame != FR_CMD);
      cen_q     <= 1'b0;
      ready_q   <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= first_bit(load_w);
    end else if (finish) begin
      sck_q     <= 1'b0;
      cen_q     <= 1'b1;
      ready_q   <= 1'b1;
    end else if (shifting && tick) begin
      if (!sck_q) begin
        sck_q     <= 1'b1;
      end else begin
        sck_q     <= 1'b0;
        bits_left <= bits_left - 5'd1;
        sreg      <= shift_word(sreg);
        mosi_q    <= next_bit(sreg);
      end
    end
  end

  assign bus.spi_sck  = sck_q;
  assign bus.spi_cen  = cen_q;
  assign bus.spi_cdn  = cdn_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.ready    = ready_q;
endmodule

// File: tb/tb_spi_screen.sv
// Self-checking bench for spi_screen: frame-timeline model compared every cycle,
// directed frames with hand-computed expectations, then random strobes.
module tb_spi_screen;
  localparam int B = 5;

`ifdef SPI_LSB_FIRST_EN
  localparam logic [15:0] EXP_2A   = 16'h0054;
  localparam logic [15:0] EXP_A55A = 16'h5AA5;
  localparam logic [15:0] EXP_34   = 16'h002C;
  localparam logic [15:0] EXP_B2B  = 16'h0F81;
`else
  localparam logic [15:0] EXP_2A   = 16'h002A;
  localparam logic [15:0] EXP_A55A = 16'hA55A;
  localparam logic [15:0] EXP_34   = 16'h0034;
  localparam logic [15:0] EXP_B2B  = 16'hF081;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  spi_screen_if bus ();

  spi_screen #(.BAUD(B)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: a frame is a payload, a bit count and the cycles elapsed since its accept edge.
  bit          m_busy    = 1'b0;
  int          m_elapsed = 0;
  int          m_n       = 8;
  logic [15:0] m_word    = '0;
  logic        m_cdn     = 1'b1;
  logic        m_hold    = 1'b0;

  // Monitor accumulators for the directed checks.
  int          rises, ready_low, cen_high, cdn_zero, cdn_one, spacing_bad, cyc, last_rise;
  logic [15:0] cap;
  logic        prev_sck = 1'b0;

  function automatic logic bitAt(logic [15:0] w, int n, int i);
`ifdef SPI_LSB_FIRST_EN
    return w[i];
`else
    return w[n - 1 - i];
`endif
  endfunction

  // Advance the reference frame timeline on each clock edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy    = 1'b0;
      m_elapsed = 0;
      m_cdn     = 1'b1;
      m_hold    = 1'b0;
    end else if (m_busy) begin
      m_elapsed++;
      if (m_elapsed == 2 * B * m_n) begin
        m_busy = 1'b0;
        m_hold = bitAt(m_word, m_n, m_n - 1);
      end
    end else if (bus.startC || bus.startD8 || bus.startD16) begin
      m_busy    = 1'b1;
      m_elapsed = 0;
      if (bus.startC) begin
        m_n = 8;  m_cdn = 1'b0; m_word = {8'h00, bus.data[7:0]};
      end else if (bus.startD8) begin
        m_n = 8;  m_cdn = 1'b1; m_word = {8'h00, bus.data[7:0]};
      end else begin
        m_n = 16; m_cdn = 1'b1; m_word = bus.data;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    logic e_sck, e_cen, e_mosi, e_ready;
    logic [4:0] got, exp;
    if (m_busy) begin
      e_sck   = ((m_elapsed % (2 * B)) >= B);
      e_mosi  = bitAt(m_word, m_n, m_elapsed / (2 * B));
      e_cen   = 1'b0;
      e_ready = 1'b0;
    end else begin
      e_sck   = 1'b0;
      e_mosi  = m_hold;
      e_cen   = 1'b1;
      e_ready = 1'b1;
    end
    got = {bus.spi_sck, bus.spi_cen, bus.spi_cdn, bus.spi_mosi, bus.ready};
    exp = {e_sck, e_cen, m_cdn, e_mosi, e_ready};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      if (miscompares < 30)
        $display("[TB] FAIL cycle_compare t=%0t sck/cen/cdn/mosi/ready got=%b expected=%b",
                 $time, got, exp);
    end
  end

  // Cycle counter for rising-edge spacing.
  always @(posedge clk) cyc++;

  // Observe sck rising edges, captured bits and phase lengths.
  always @(negedge clk) begin
    if (!prev_sck && bus.spi_sck) begin
      rises++;
      cap = {cap[14:0], bus.spi_mosi};
      if (rises > 1 && (cyc - last_rise) != 2 * B) spacing_bad++;
      last_rise = cyc;
    end
    prev_sck = bus.spi_sck;
    if (!bus.ready) ready_low++;
    if (bus.spi_cen) cen_high++;
    if (!bus.spi_cen && !bus.spi_cdn) cdn_zero++;
    if (!bus.spi_cen && bus.spi_cdn) cdn_one++;
  end

  task automatic clearMon();
    rises = 0; ready_low = 0; cen_high = 0; cdn_zero = 0; cdn_one = 0;
    spacing_bad = 0; cap = '0; last_rise = 0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic d8, input logic d16, input logic [15:0] d);
    @(posedge clk);
    #1;
    bus.startC = c; bus.startD8 = d8; bus.startD16 = d16; bus.data = d;
    @(posedge clk);
    #1;
    bus.startC = 1'b0; bus.startD8 = 1'b0; bus.startD16 = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.ready) begin ok = 1'b1; break; end
    end
    checkOutput({name, "_done"}, int'(ok), 1);
  endtask

  initial begin
    bus.startC = 1'b0; bus.startD8 = 1'b0; bus.startD16 = 1'b0; bus.data = '0;
    clearMon();
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {bus.spi_sck, bus.spi_cen, bus.spi_cdn, bus.spi_mosi, bus.ready}, 5'b01101);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Command 0x2A with an ignored startD8 in the middle of the frame.
    clearMon();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h002A);
    repeat (23) @(posedge clk);
    #1 bus.startD8 = 1'b1; bus.data = 16'hFFFF;
    @(posedge clk);
    #1 bus.startD8 = 1'b0;
    waitDone("cmd2a");
    checkOutput("cmd2a_rises", rises, 8);
    checkOutput("cmd2a_bits", cap, EXP_2A);
    checkOutput("cmd2a_spacing", spacing_bad, 0);
    checkOutput("cmd2a_ready_low", ready_low, 80);
    checkOutput("cmd2a_cdn_low", cdn_zero, 80);
    repeat (30) @(negedge clk);
    checkOutput("no_second_frame", ready_low, 80);

    // 16-bit data frame.
    clearMon();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hA55A);
    waitDone("d16");
    checkOutput("d16_rises", rises, 16);
    checkOutput("d16_bits", cap, EXP_A55A);
    checkOutput("d16_ready_low", ready_low, 160);
    checkOutput("d16_cdn_high", cdn_one, 160);

    // startC and startD16 together: command wins.
    clearMon();
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h1234);
    waitDone("prio");
    checkOutput("prio_rises", rises, 8);
    checkOutput("prio_bits", cap, EXP_34);
    checkOutput("prio_cdn_low", cdn_zero, 80);

    // Back-to-back data frames on the first ready cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h00F0);
    clearMon();
    waitDone("b2b_first");
    bus.startD8 = 1'b1; bus.data = 16'h0081;
    @(posedge clk);
    #1 bus.startD8 = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("b2b_cen_gap", cen_high, 1);
    checkOutput("b2b_accepted", int'(bus.ready), 0);
    waitDone("b2b_second");
    checkOutput("b2b_rises", rises, 16);
    checkOutput("b2b_bits", cap, EXP_B2B);

    // Reset in the middle of a frame of ones.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF);
    repeat (37) @(posedge clk);
    #2 rstn = 1'b0;
    @(negedge clk);
    checkOutput("reset_midframe",
                {bus.spi_sck, bus.spi_cen, bus.spi_cdn, bus.spi_mosi, bus.ready}, 5'b01101);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_stays_idle", int'(bus.ready), 1);

    // Random strobes and payloads, checked by the per-cycle model compare.
    repeat (6000) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 24) == 0) begin
        bus.startC   = 1'($urandom);
        bus.startD8  = 1'($urandom);
        bus.startD16 = 1'($urandom);
        bus.data     = 16'($urandom);
      end else begin
        bus.startC = 1'b0; bus.startD8 = 1'b0; bus.startD16 = 1'b0;
      end
    end
    bus.startC = 1'b0; bus.startD8 = 1'b0; bus.startD16 = 1'b0;
    repeat (400) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
